xpb_table_gen: RTL and testbench



---
 rtl/xpb_table_gen.sv | 142 ++++++++++++++
 tb/tb_xpb_table_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xpb_table_gen.sv
// xpb_table_gen
//   Generates the xpb reduction table T[j] = (j * 2^SHIFT) mod M for
//   j = 0 .. 2^IDX_W-1 and streams it into a table RAM, one entry per cycle.
//   The base 2^SHIFT mod M is built by SHIFT modular doublings, and the
//   entries are then produced by repeated modular addition of that base.
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   start    in   single-cycle request, sampled only while idle
//   modulus  in   M (2 <= M < 2^DATA_W), sampled with start
//   shift    in   bit position SHIFT, sampled with start
//   busy     out  high whenever a run is in progress
//   done     out  one-cycle pulse after the last table write
//   wr_en    out  table write strobe
//   wr_addr  out  table index j
//   wr_data  out  table entry T[j]
module xpb_table_gen #(
   parameter int DATA_W  = 1024,
   parameter int IDX_W   = 5,
   parameter int SHIFT_W = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [DATA_W-1:0]  modulus,
   input  logic [SHIFT_W-1:0] shift,
   output logic               busy,
   output logic               done,
   output logic               wr_en,
   output logic [IDX_W-1:0]   wr_addr,
   output logic [DATA_W-1:0]  wr_data
);

   typedef enum logic [1:0] {
      IDLE,
      DOUBLE,
      FILL,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [DATA_W-1:0]  m_q;
   logic [DATA_W-1:0]  base_q;
   logic [DATA_W-1:0]  acc_q;
   logic [SHIFT_W-1:0] cnt_q;
   logic [IDX_W-1:0]   j_q;

   // One extra bit keeps 2*base and acc+base exact for any legal M.
   logic [DATA_W:0]    m_ext;
   logic [DATA_W:0]    dbl;
   logic [DATA_W:0]    sum;
   logic [DATA_W-1:0]  base_nxt;
   logic [DATA_W-1:0]  acc_nxt;

   // Both operands stay below M, so one conditional subtract reduces fully.
   always_comb begin
      m_ext    = {1'b0, m_q};
      dbl      = {base_q, 1'b0};
      sum      = {1'b0, acc_q} + {1'b0, base_q};
      base_nxt = (dbl >= m_ext) ? DATA_W'(dbl - m_ext) : DATA_W'(dbl);
      acc_nxt  = (sum >= m_ext) ? DATA_W'(sum - m_ext) : DATA_W'(sum);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (shift != '0) ? DOUBLE : FILL;
            end
         end
         DOUBLE: begin
            if (cnt_q == SHIFT_W'(1)) begin
               state_d = FILL;
            end
         end
         FILL: begin
            if (j_q == '1) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q    <= '0;
         base_q <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         j_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  m_q    <= modulus;
                  base_q <= DATA_W'(1);
                  cnt_q  <= shift;
                  acc_q  <= '0;
                  j_q    <= '0;
               end
            end
            DOUBLE: begin
               base_q <= base_nxt;
               cnt_q  <= cnt_q - 1'b1;
            end
            FILL: begin
               acc_q <= acc_nxt;
               // Hold at the last index rather than wrapping back to 0.
               if (j_q != '1) begin
                  j_q <= j_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign wr_en   = (state_q == FILL);
   assign wr_addr = j_q;
   assign wr_data = acc_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
module tb_xpb_table_gen;

   localparam int SW   = 16;
   localparam int LW   = 1024;
   localparam int IW   = 5;
   localparam int NENT = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // Small instance (DATA_W = 16)
   logic          s_start = 1'b0;
   logic [SW-1:0] s_mod = '0;
   logic [10:0]   s_shift = '0;
   logic          s_busy, s_done, s_wr_en;
   logic [IW-1:0] s_wr_addr;
   logic [SW-1:0] s_wr_data;

   // Default instance (DATA_W = 1024)
   logic          l_start = 1'b0;
   logic [LW-1:0] l_mod = '0;
   logic [10:0]   l_shift = '0;
   logic          l_busy, l_done, l_wr_en;
   logic [IW-1:0] l_wr_addr;
   logic [LW-1:0] l_wr_data;

   xpb_table_gen #(.DATA_W(SW), .IDX_W(IW), .SHIFT_W(11)) u_small (
      .clk(clk), .rst_n(rst_n), .start(s_start), .modulus(s_mod), .shift(s_shift),
      .busy(s_busy), .done(s_done), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data)
   );

   xpb_table_gen u_large (
      .clk(clk), .rst_n(rst_n), .start(l_start), .modulus(l_mod), .shift(l_shift),
      .busy(l_busy), .done(l_done), .wr_en(l_wr_en), .wr_addr(l_wr_addr), .wr_data(l_wr_data)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got low160=%h, expected low160=%h, upper bits differ=%0b",
                  name, $time, act[159:0], exp[159:0], act[LW-1:160] !== exp[LW-1:160]);
      end
   endtask

   // Reference: (j * 2^sh) mod m evaluated directly with wide integer arithmetic.
   function automatic logic [LW-1:0] ref_entry(input int j, input int sh, input logic [LW-1:0] m);
      logic [2111:0] x;
      logic [2111:0] mm;
      x  = 2112'(j);
      x  = x << sh;
      mm = 2112'(m);
      return LW'(x % mm);
   endfunction

   // Expected timeline per run: cycle k after the start edge.
   //   k = 1..sh          : busy, no write
   //   k = sh+1..sh+NENT  : write of entry k-sh-1
   //   k = sh+NENT+1      : done
   //   k = sh+NENT+2      : idle again
   bit            s_act = 1'b0;
   int            s_k = 0;
   int            s_sh = 0;
   logic [SW-1:0] s_m = '0;
   logic [SW-1:0] s_tab [NENT];

   bit            l_act = 1'b0;
   int            l_k = 0;
   int            l_sh = 0;
   logic [LW-1:0] l_m = '0;
   logic [LW-1:0] l_tab [NENT];

   always @(negedge clk) begin
      if (s_act) begin
         s_k++;
         chk_bit("s_busy", s_busy, s_k <= s_sh + NENT + 1);
         chk_bit("s_done", s_done, s_k == s_sh + NENT + 1);
         chk_bit("s_wr_en", s_wr_en, (s_k > s_sh) && (s_k <= s_sh + NENT));
         if ((s_k > s_sh) && (s_k <= s_sh + NENT)) begin
            chk_int("s_wr_addr", int'(s_wr_addr), s_k - s_sh - 1);
            chk_vec("s_wr_data", LW'(s_wr_data), LW'(s_tab[s_k - s_sh - 1]));
            chk_bit("s_data_lt_m", s_wr_data < s_m, 1'b1);
         end
         if (s_k >= s_sh + NENT + 2) s_act = 1'b0;
      end else begin
         chk_bit("s_idle_busy", s_busy, 1'b0);
         chk_bit("s_idle_done", s_done, 1'b0);
         chk_bit("s_idle_wr_en", s_wr_en, 1'b0);
      end
   end

   always @(negedge clk) begin
      if (l_act) begin
         l_k++;
         chk_bit("l_busy", l_busy, l_k <= l_sh + NENT + 1);
         chk_bit("l_done", l_done, l_k == l_sh + NENT + 1);
         chk_bit("l_wr_en", l_wr_en, (l_k > l_sh) && (l_k <= l_sh + NENT));
         if ((l_k > l_sh) && (l_k <= l_sh + NENT)) begin
            chk_int("l_wr_addr", int'(l_wr_addr), l_k - l_sh - 1);
            chk_vec("l_wr_data", l_wr_data, l_tab[l_k - l_sh - 1]);
         end
         if (l_k >= l_sh + NENT + 2) l_act = 1'b0;
      end else begin
         chk_bit("l_idle_busy", l_busy, 1'b0);
         chk_bit("l_idle_done", l_done, 1'b0);
         chk_bit("l_idle_wr_en", l_wr_en, 1'b0);
      end
   end

   // Model state switches over at the start edge so a finishing run is
   // still checked against its own table.
   task automatic run_s(input logic [SW-1:0] m, input int sh);
      logic [SW-1:0] tab [NENT];
      for (int j = 0; j < NENT; j++) tab[j] = SW'(ref_entry(j, sh, LW'(m)));
      @(posedge clk);
      #1;
      s_mod   = m;
      s_shift = 11'(sh);
      s_start = 1'b1;
      @(posedge clk);
      s_tab = tab;
      s_sh  = sh;
      s_m   = m;
      s_k   = 0;
      s_act = 1'b1;
      #1;
      s_start = 1'b0;
      s_mod   = SW'($urandom);
      s_shift = 11'($urandom);
   endtask

   task automatic wait_done_s(input string name, input int exp_lat);
      int n;
      n = 0;
      while (!s_done && n < exp_lat + 20) begin
         @(negedge clk);
         n++;
      end
      chk_int(name, n, exp_lat);
   endtask

   initial begin
      logic [LW-1:0] big_m;
      int            sh;
      logic [SW-1:0] m;
      int            n;

      #2;
      chk_bit("rst_busy", s_busy, 1'b0);
      chk_bit("rst_done", s_done, 1'b0);
      chk_bit("rst_wr_en", s_wr_en, 1'b0);
      chk_int("rst_wr_addr", int'(s_wr_addr), 0);
      chk_vec("rst_wr_data", LW'(s_wr_data), '0);
      chk_vec("rst_l_wr_data", l_wr_data, '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // M = 251, SHIFT = 10
      run_s(16'd251, 10);
      chk_vec("model_T1", LW'(s_tab[1]), LW'(20));
      chk_vec("model_T12", LW'(s_tab[12]), LW'(240));
      chk_vec("model_T13", LW'(s_tab[13]), LW'(9));
      chk_vec("model_T31", LW'(s_tab[31]), LW'(118));
      wait_done_s("lat_m251_sh10", 43);

      // Back-to-back: M = 3, SHIFT = 5
      run_s(16'd3, 5);
      chk_vec("model_m3_T1", LW'(s_tab[1]), LW'(2));
      chk_vec("model_m3_T2", LW'(s_tab[2]), LW'(1));
      chk_vec("model_m3_T31", LW'(s_tab[31]), LW'(2));
      wait_done_s("lat_m3_sh5", 38);

      // SHIFT = 0 goes straight to FILL
      run_s(16'd251, 0);
      chk_vec("model_sh0_T5", LW'(s_tab[5]), LW'(5));
      wait_done_s("lat_sh0", 33);

      // Largest 16-bit modulus
      run_s(16'hFFFF, 20);
      chk_vec("model_mmax_T1", LW'(s_tab[1]), LW'(16));
      chk_vec("model_mmax_T31", LW'(s_tab[31]), LW'(496));
      wait_done_s("lat_mmax", 53);

      // Random moduli and shifts
      for (int r = 0; r < 6; r++) begin
         m  = SW'($urandom_range(65535, 2));
         sh = int'($urandom_range(40, 0));
         run_s(m, sh);
         wait_done_s("lat_rand", sh + NENT + 1);
      end

      // start during FILL is ignored
      run_s(16'd251, 10);
      wait (s_k == s_sh + 5);
      @(posedge clk);
      #1;
      s_mod   = 16'd7;
      s_shift = 11'd3;
      s_start = 1'b1;
      @(posedge clk);
      #1 s_start = 1'b0;
      wait (!s_act);

      // Reset while entry 7 is being written
      run_s(16'd251, 10);
      wait (s_k == s_sh + 1 + 7);
      #1;
      rst_n = 1'b0;
      s_act = 1'b0;
      #1;
      chk_bit("midrst_busy", s_busy, 1'b0);
      chk_bit("midrst_wr_en", s_wr_en, 1'b0);
      chk_bit("midrst_done", s_done, 1'b0);
      chk_int("midrst_wr_addr", int'(s_wr_addr), 0);
      chk_vec("midrst_wr_data", LW'(s_wr_data), '0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Full table after the aborted run
      run_s(16'd251, 10);
      wait_done_s("lat_after_rst", 43);
      wait (!s_act);

      // Default widths: random odd 1024-bit M with the top bit set, SHIFT = 1024
      for (int w = 0; w < LW / 32; w++) big_m[w*32 +: 32] = $urandom;
      big_m[LW-1] = 1'b1;
      big_m[0]    = 1'b1;
      for (int j = 0; j < NENT; j++) l_tab[j] = ref_entry(j, 1024, big_m);
      @(posedge clk);
      #1;
      l_mod   = big_m;
      l_shift = 11'd1024;
      l_start = 1'b1;
      @(posedge clk);
      l_sh  = 1024;
      l_m   = big_m;
      l_k   = 0;
      l_act = 1'b1;
      #1;
      l_start = 1'b0;
      l_mod   = '0;
      n = 0;
      while (!l_done && n < 1100) begin
         @(negedge clk);
         n++;
      end
      chk_int("lat_1024", n, 1057);
      wait (!l_act);
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
